// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through and runs the data-bus handshake
// for loads/stores, including big-endian lane extraction and store byte enables.
module mem_access #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] st_data,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        stallreq,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [3:0]  d_sel,
  output logic [31:0] d_wdata,
  input  logic [31:0] d_rdata,
  input  logic        d_ack,
  output logic        align_err,
  output logic        bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rbuf_q, rbuf_d;
  logic            err_q, err_d;

  logic            is_load, is_store, misalign, start, req;
  logic [1:0]      lane;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     load_val, st_rep;
  logic [3:0]      sel;

  // Operation decode; opcodes 9-15 fall out as neither load nor store.
  assign lane     = mem_addr[1:0];
  assign is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
  assign is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
  assign misalign = (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && mem_addr[0])
                 || (((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'b00));
  assign start    = (is_load || is_store) && !misalign;
  assign req      = rst && !flush && (((state_q == S_IDLE) && start) || (state_q == S_WAIT));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    err_d   = err_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (d_ack) begin
              state_d = S_DONE;
              rbuf_d  = d_rdata;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CW'(1);
            end
          end
        end
        S_WAIT: begin
          if (d_ack) begin
            state_d = S_DONE;
            rbuf_d  = d_rdata;
          end else if (cnt_q == CW'(TIMEOUT_CYC)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      err_q   <= err_d;
    end
  end

  // Big-endian lanes: lane 0 is the most significant byte of the word.
  always_comb begin
    unique case (lane)
      2'd0:    ld_byte = rbuf_q[31:24];
      2'd1:    ld_byte = rbuf_q[23:16];
      2'd2:    ld_byte = rbuf_q[15:8];
      default: ld_byte = rbuf_q[7:0];
    endcase
    ld_half = lane[1] ? rbuf_q[15:0] : rbuf_q[31:16];
    unique case (mem_op)
      OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_val = {24'h0, ld_byte};
      OP_LH:   load_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_val = {16'h0, ld_half};
      OP_LW:   load_val = rbuf_q;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    unique case (mem_op)
      OP_SB: begin
        sel    = 4'b1000 >> lane;
        st_rep = {4{st_data[7:0]}};
      end
      OP_SH: begin
        sel    = lane[1] ? 4'b0011 : 4'b1100;
        st_rep = {2{st_data[15:0]}};
      end
      default: begin
        sel    = 4'b1111;
        st_rep = st_data;
      end
    endcase
  end

  assign stallreq  = req;
  assign d_req     = req;
  assign align_err = rst && misalign;

  // Request cycles are bubbles to mem_wb; the write happens in DONE.
  always_comb begin
    mem_wd    = '0;
    mem_wreg  = 1'b0;
    mem_wdata = '0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_sel     = '0;
    d_wdata   = '0;
    bus_err   = 1'b0;
    if (req) begin
      d_we      = is_store;
      d_addr    = {mem_addr[31:2], 2'b00};
      d_sel     = sel;
      d_wdata   = is_store ? st_rep : '0;
      mem_wd    = ex_wd;
      mem_wdata = ex_wdata;
    end else if (rst && !flush) begin
      mem_wd = ex_wd;
      if (state_q == S_DONE) begin
        bus_err = err_q;
        if (is_load) begin
          mem_wreg  = ex_wreg && !err_q;
          mem_wdata = err_q ? '0 : load_val;
        end else begin
          mem_wdata = ex_wdata;
        end
      end else begin
        mem_wreg  = ex_wreg && !misalign;
        mem_wdata = ex_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: table of accesses run through a bus responder, with
// expected write-back results queued at issue and compared when the stall ends.
module tb_mem_access;

  localparam int unsigned TO = 4;

  localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4,
                         LW = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic        clk, rst, flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, st_data;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq, d_req, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_sel;
  logic        d_ack, align_err, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_access #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .st_data(st_data),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq(stallreq), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_sel(d_sel), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .align_err(align_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] rdata;
    int          ack_at;     // request cycle index carrying d_ack; >= 99 means never
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    int          stall;
    logic        align;
    logic        e_wreg;
    logic [31:0] e_wdata;
    bit          chk_wdata;
    logic        e_berr;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_dwdata;
  } vec_t;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    bit          chk_wdata;
    logic        berr;
    int          stall;
    logic        align;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   k;
    bit   done;
    @(posedge clk); #1;
    mem_op = v.op; mem_addr = v.addr; st_data = v.st;
    ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.wdata;
    d_ack = 1'b0; flush = 1'b0;
    sb.push_back('{v.wd, v.wreg ? v.e_wreg : 1'b0, v.e_wdata, v.chk_wdata, v.e_berr, v.stall, v.align});
    k = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (stallreq) begin
        if (k == 0) begin
          check($sformatf("v%0d d_req", idx), 32'(d_req), 32'd1);
          check($sformatf("v%0d d_we", idx), 32'(d_we), 32'(v.e_we));
          check($sformatf("v%0d d_addr", idx), d_addr, v.addr & 32'hFFFF_FFFC);
          check($sformatf("v%0d d_sel", idx), 32'(d_sel), 32'(v.e_sel));
          if (v.e_we) check($sformatf("v%0d d_wdata", idx), d_wdata, v.e_dwdata);
        end
        if (k == v.ack_at) begin
          d_ack = 1'b1;
          d_rdata = v.rdata;
        end
        @(posedge clk); #1;
        d_ack = 1'b0;
        d_rdata = 32'h5A5A_A5A5;
        k++;
        if (k > 40) begin
          n_checks++;
          n_errors++;
          $display("FAIL v%0d stall_bound: still stalled after %0d cycles, expected %0d", idx, k, v.stall);
          e = sb.pop_front();
          done = 1'b1;
        end
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d stall_cycles", idx), 32'(k), 32'(e.stall));
        check($sformatf("v%0d d_req_idle", idx), 32'(d_req), 32'd0);
        check($sformatf("v%0d align_err", idx), 32'(align_err), 32'(e.align));
        check($sformatf("v%0d mem_wd", idx), 32'(mem_wd), 32'(e.wd));
        check($sformatf("v%0d mem_wreg", idx), 32'(mem_wreg), 32'(e.wreg));
        if (e.chk_wdata) check($sformatf("v%0d mem_wdata", idx), mem_wdata, e.wdata);
        check($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'(e.berr));
        done = 1'b1;
      end
    end
  endtask

  // Kill an access in WAIT (flush or reset) while d_ack arrives, then rerun it.
  task automatic kill_in_wait(input bit use_rst, input string tag);
    @(posedge clk); #1;
    mem_op = LW; mem_addr = 32'h80; ex_wd = 5'd11; ex_wreg = 1'b1; ex_wdata = 32'h5;
    d_ack = 1'b0; flush = 1'b0;
    @(negedge clk);
    check({tag, " req_stall"}, 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " wait_stall"}, 32'(stallreq), 32'd1);
    if (use_rst) rst = 1'b0; else flush = 1'b1;
    d_ack = 1'b1;
    d_rdata = 32'hDEAD_BEEF;
    #1;
    check({tag, " kill_stall"}, 32'(stallreq), 32'd0);
    check({tag, " kill_d_req"}, 32'(d_req), 32'd0);
    check({tag, " kill_wreg"}, 32'(mem_wreg), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; d_ack = 1'b0;
    @(negedge clk);
    check({tag, " reissue_stall"}, 32'(stallreq), 32'd1);
    check({tag, " reissue_d_req"}, 32'(d_req), 32'd1);
    d_ack = 1'b1;
    d_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    d_ack = 1'b0;
    @(negedge clk);
    check({tag, " done_stall"}, 32'(stallreq), 32'd0);
    check({tag, " done_wreg"}, 32'(mem_wreg), 32'd1);
    check({tag, " done_wdata"}, mem_wdata, 32'h0BAD_F00D);
    @(posedge clk); #1;
    mem_op = NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    // op, addr, st, rdata, ack_at, wd, wreg, wdata, stall, align, e_wreg, e_wdata, chk, berr, we, sel, dwdata
    vecs.push_back('{NONE, 32'h0,   32'h0,         32'h0,         0,  5'd3,  1'b1, 32'h1234, 0, 1'b0, 1'b1, 32'h1234,      1'b1, 1'b0, 1'b0, 4'h0,    32'h0});
    vecs.push_back('{LB,   32'h101, 32'h0,         32'h11F2_3344, 0,  5'd4,  1'b1, 32'hAAAA, 1, 1'b0, 1'b1, 32'hFFFF_FFF2, 1'b1, 1'b0, 1'b0, 4'hF,    32'h0});
    vecs.push_back('{SH,   32'h202, 32'h1234_ABCD, 32'h0,         3,  5'd5,  1'b1, 32'h0202, 4, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'b0011, 32'hABCD_ABCD});
    vecs.push_back('{LW,   32'h3,   32'h0,         32'h0,         0,  5'd6,  1'b1, 32'h0033, 0, 1'b1, 1'b0, 32'h0033,      1'b1, 1'b0, 1'b0, 4'h0,    32'h0});
    vecs.push_back('{LW,   32'h10,  32'h0,         32'h0,         99, 5'd7,  1'b1, 32'h0044, 5, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 4'hF,    32'h0});
    vecs.push_back('{LW,   32'h14,  32'h0,         32'hCAFE_BABE, 1,  5'd8,  1'b1, 32'h0,    2, 1'b0, 1'b1, 32'hCAFE_BABE, 1'b1, 1'b0, 1'b0, 4'hF,    32'h0});
    vecs.push_back('{LBU,  32'h3,   32'h0,         32'h11F2_3380, 0,  5'd9,  1'b1, 32'h0,    1, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 4'hF,    32'h0});
    vecs.push_back('{LH,   32'h2,   32'h0,         32'h1234_8001, 2,  5'd10, 1'b1, 32'h0,    3, 1'b0, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 4'hF,    32'h0});
    vecs.push_back('{LHU,  32'h0,   32'h0,         32'h9ABC_0000, 0,  5'd11, 1'b1, 32'h0,    1, 1'b0, 1'b1, 32'h0000_9ABC, 1'b1, 1'b0, 1'b0, 4'hF,    32'h0});
    vecs.push_back('{LB,   32'h0,   32'h0,         32'h7F00_0000, 0,  5'd12, 1'b1, 32'h0,    1, 1'b0, 1'b1, 32'h0000_007F, 1'b1, 1'b0, 1'b0, 4'hF,    32'h0});
    vecs.push_back('{SB,   32'h31,  32'h55AA_66C3, 32'h0,         0,  5'd13, 1'b1, 32'h0,    1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'b0100, 32'hC3C3_C3C3});
    vecs.push_back('{SW,   32'h40,  32'hDEAD_BEEF, 32'h0,         1,  5'd14, 1'b1, 32'h0,    2, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'hF,    32'hDEAD_BEEF});
    vecs.push_back('{SH,   32'h1,   32'h0,         32'h0,         0,  5'd15, 1'b1, 32'h0066, 0, 1'b1, 1'b0, 32'h0066,      1'b1, 1'b0, 1'b0, 4'h0,    32'h0});
    vecs.push_back('{4'd12,32'h0,   32'h0,         32'h0,         0,  5'd9,  1'b1, 32'h0077, 0, 1'b0, 1'b1, 32'h0077,      1'b1, 1'b0, 1'b0, 4'h0,    32'h0});
    vecs.push_back('{LH,   32'h4,   32'h0,         32'h7ABC_1234, 0,  5'd16, 1'b1, 32'h0,    1, 1'b0, 1'b1, 32'h0000_7ABC, 1'b1, 1'b0, 1'b0, 4'hF,    32'h0});
    vecs.push_back('{LB,   32'h2,   32'h0,         32'h0000_FF00, 0,  5'd17, 1'b0, 32'h0,    1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 4'hF,    32'h0});
    vecs.push_back('{SH,   32'h200, 32'h0000_BEEF, 32'h0,         0,  5'd18, 1'b1, 32'h0,    1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'b1100, 32'hBEEF_BEEF});

    // Reset with a pending, misaligned-looking op and a stray ack: all outputs low.
    rst = 1'b0; flush = 1'b0;
    mem_op = LW; mem_addr = 32'h9; st_data = 32'h1; ex_wd = 5'd5; ex_wreg = 1'b1;
    ex_wdata = 32'hFFFF; d_ack = 1'b1; d_rdata = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst mem_wd", 32'(mem_wd), 32'd0);
    check("rst mem_wreg", 32'(mem_wreg), 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst stallreq", 32'(stallreq), 32'd0);
    check("rst d_req", 32'(d_req), 32'd0);
    check("rst d_sel", 32'(d_sel), 32'd0);
    check("rst align_err", 32'(align_err), 32'd0);
    check("rst bus_err", 32'(bus_err), 32'd0);

    // d_ack with no request in IDLE must be ignored.
    @(posedge clk); #1;
    rst = 1'b1; mem_op = NONE; d_ack = 1'b1; d_rdata = 32'h0F0F_0F0F;
    @(negedge clk);
    check("idle_ack stallreq", 32'(stallreq), 32'd0);
    check("idle_ack d_req", 32'(d_req), 32'd0);
    check("idle_ack mem_wreg", 32'(mem_wreg), 32'd1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    kill_in_wait(1'b0, "flush");
    kill_in_wait(1'b1, "rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
